// File: rtl/multi_edge_detector.sv
// Per-channel synchronise, glitch-filter and edge-detect, with sticky interrupt status per channel.
// Latency: input change to level/rise/fall is SYNC_STAGES+FILTER_CYCLES-1 cycles after the capturing edge.
// No backpressure: the block runs continuously; irq_status holds until cleared.
module multi_edge_detector #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     signal,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     irq_clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall,
    output logic [WIDTH-1:0]     edge_pulse,
    output logic [WIDTH-1:0]     irq_status,
    output logic                 irq
);

    localparam int CW = $clog2(FILTER_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= signal;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Level only moves after the new value has been seen FILTER_CYCLES times in a row;
    // rise/fall are registered alongside it so they line up with the level change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level <= '0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == level[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i] <= '0;
                    level[i] <= sync_out[i];
                    rise[i]  <= sync_out[i];
                    fall[i]  <= ~sync_out[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        edge_pulse = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_pulse[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);
        end
    end

    // Set takes priority over clear when both land on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | edge_pulse;
        end
    end

    assign irq = |irq_status;

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Parametrised, multi-channel successor to the single-bit rising-edge detector. Each channel synchronises an asynchronous input, glitch-filters it, and detects rising and falling edges. Each channel has a selectable edge mode, and qualified edges set sticky interrupt status bits. The block sits between raw external/pin-level signals and the interrupt/control logic.

Parameters:
WIDTH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
FILTER_CYCLES, 3, consecutive cycles a new synchronised value must persist before the filtered level changes (>=1)

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst_n  input  1  reset, synchronous, active-low
signal  input  WIDTH  raw input per channel, may be asynchronous to clk
mode  input  2*WIDTH  per-channel edge mode, bits [2i+1:2i] for channel i: 00 off, 01 rise, 10 fall, 11 both
irq_clr  input  WIDTH  per-channel clear of irq_status, sampled on posedge clk
level  output  WIDTH  filtered, synchronised level per channel
rise  output  WIDTH  one-cycle pulse when level goes 0->1
fall  output  WIDTH  one-cycle pulse when level goes 1->0
edge_pulse  output  WIDTH  one-cycle pulse for edges qualified by mode
irq_status  output  WIDTH  sticky per-channel edge-seen flag
irq  output  1  OR-reduction of irq_status

Behaviour:
- Reset: on a posedge with rst_n=0, all of the following are cleared to 0: synchroniser flops, filter counters, level, rise, fall, edge_pulse, irq_status. irq is therefore 0 in the cycle after reset.
- Reset mid-operation discards pending filter counts and pulses. A channel whose input is high when reset releases produces a rise after the full latency; this is intended.
- Synchroniser: a chain of SYNC_STAGES flops per channel. sync_out is the last stage.
- Filter: one counter per channel, width clog2(FILTER_CYCLES)+1. On each posedge:
  - If sync_out == level, the counter is set to 0.
  - Else, if counter == FILTER_CYCLES-1, level <= sync_out and counter <= 0.
  - Else, counter <= counter+1.
- Filter consequences:
  - Any pulse on sync_out shorter than FILTER_CYCLES cycles never reaches level.
  - A glitch back to the old value restarts the count.
- Edge outputs are registered and asserted in the same cycle level changes:
  - rise[i] = 1 for exactly one cycle when level[i] goes 0->1.
  - fall[i] = 1 for exactly one cycle when level[i] goes 1->0.
  - rise and fall are never both high on the same channel.
- Latency: an input change that meets setup before posedge N appears on level, rise and fall after posedge N+SYNC_STAGES+FILTER_CYCLES-1. With defaults this is posedge N+4, i.e. 5 edges counting posedge N.
- Minimum spacing between successive edges on one channel is FILTER_CYCLES cycles.
- edge_pulse[i] = (rise[i] & mode[2i]) | (fall[i] & mode[2i+1]), combinational from the registered rise/fall and the current mode. Mode 00 suppresses edge_pulse but not rise/fall/level.
- irq_status[i] priority:
  - edge_pulse[i]=1 sets it on the next posedge.
  - irq_clr[i]=1 clears it.
  - If both occur on the same edge, set wins and the bit stays 1.
  - A clear with no pending status has no effect.
- irq = |irq_status, combinational.
- Channels are fully independent. Simultaneous edges on all channels are each captured.
- Mode changes take effect immediately on edge_pulse; they do not retroactively set irq_status.

Test Plan:
- Reset, WIDTH=8, defaults: hold rst_n=0 for 3 cycles with signal=8'hFF -> all outputs 0. Release -> rise=8'hFF for one cycle exactly 5 posedges after the first non-reset posedge; level=8'hFF thereafter.
- Filter, mode=01 on ch0: assert signal[0] for 2 cycles then deassert -> level[0], rise[0] and irq_status[0] stay 0. Assert for 3 cycles -> rise[0] pulses once, irq_status[0]=1, irq=1. Deassert -> fall[0] pulses once; edge_pulse[0] stays 0 on the fall.
- Mode sweep on ch1 (00, 01, 10, 11), drive a 0->1->0 pulse 10 cycles wide for each -> edge_pulse[1] count is 0, 1, 1, 2 respectively; rise[1] and fall[1] are 1 each in every case.
- Sticky and clear: set irq_status[2] via a rise, then pulse irq_clr[2] -> 0 next cycle. Align irq_clr[2] with the cycle edge_pulse[2]=1 -> irq_status[2] stays 1.
- Mid-operation reset: drive signal[3] high, pull rst_n low 2 cycles after the change -> no rise[3] before reset. After release, rise[3] appears 5 posedges later.
- Independence: toggle all 8 channels simultaneously with mode=all 11 -> edge_pulse=8'hFF for one cycle and irq_status=8'hFF. Clear only ch5 -> irq_status=8'hDF and irq stays 1.
